// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit
//  Purpose  : Iterative multi-cycle integer multiply/divide unit with HI/LO
//             result registers. Handles MULT, MULTU, DIV, DIVU, MTHI, MTLO.
//             One product/quotient bit per cycle, start/busy/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mdOp,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // Counter value seen on the final RUN edge (E_WIDTH).
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  // Multiply: full 2*WIDTH product accumulator, multiplier consumed from bit 0.
  // Divide:   low half holds dividend bits shifting out / quotient shifting in.
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     rem_q, rem_d;       // restoring-divide partial remainder
  logic [WIDTH-1:0]   opb_q, opb_d;       // multiplicand or divisor magnitude
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d; // negate product / quotient at FIX
  logic               neg_hi_q, neg_hi_d; // negate remainder at FIX
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Combinational helpers
  logic               is_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial, div_diff;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed, rem_fixed;

  // Next-state, datapath step and result formatting
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    prod_d     = prod_q;
    rem_d      = rem_q;
    opb_d      = opb_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    is_signed  = (mdOp == OP_MULT) || (mdOp == OP_DIV);
    a_neg      = is_signed & opA[WIDTH-1];
    b_neg      = is_signed & opB[WIDTH-1];
    // Two's-complement negation of -2^(W-1) yields 2^(W-1) as an unsigned magnitude.
    mag_a      = a_neg ? (~opA + 1'b1) : opA;
    mag_b      = b_neg ? (~opB + 1'b1) : opB;

    mul_sum    = prod_q[0] ? ({1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q})
                           : {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    div_trial  = {rem_q[WIDTH-1:0], prod_q[WIDTH-1]};
    div_diff   = div_trial - {1'b0, opb_q};

    prod_fixed = neg_lo_q ? (~prod_q + 1'b1) : prod_q;
    quo_fixed  = neg_lo_q ? (~prod_q[WIDTH-1:0] + 1'b1) : prod_q[WIDTH-1:0];
    rem_fixed  = neg_hi_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (mdOp)
            OP_MULT, OP_MULTU: begin
              prod_d     = {{WIDTH{1'b0}}, mag_b};
              opb_d      = mag_a;
              rem_d      = '0;
              is_div_d   = 1'b0;
              neg_lo_d   = a_neg ^ b_neg;
              neg_hi_d   = 1'b0;
              div_zero_d = 1'b0;
              count_d    = '0;
              state_d    = ST_RUN;
            end
            OP_DIV, OP_DIVU: begin
              prod_d     = {{WIDTH{1'b0}}, mag_a};
              opb_d      = mag_b;
              rem_d      = '0;
              is_div_d   = 1'b1;
              neg_lo_d   = a_neg ^ b_neg;
              neg_hi_d   = a_neg;
              div_zero_d = (opB == '0);
              count_d    = '0;
              state_d    = ST_RUN;
            end
            OP_MTHI: hi_d = opA;
            OP_MTLO: lo_d = opA;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (is_div_q) begin
          // Restoring step: a clear sign bit means the divisor fitted.
          if (!div_diff[WIDTH]) begin
            rem_d  = div_diff;
            prod_d = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d  = div_trial;
            prod_d = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          prod_d = {mul_sum, prod_q[WIDTH-1:1]};
        end
        count_d = count_q + 1'b1;
        if (count_q == LAST_STEP) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (is_div_q) begin
          // Divide by zero: remainder path already reproduces opA.
          lo_d = div_zero_q ? {WIDTH{1'b1}} : quo_fixed;
          hi_d = rem_fixed;
        end else begin
          hi_d = prod_fixed[2*WIDTH-1:WIDTH];
          lo_d = prod_fixed[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      prod_q     <= '0;
      rem_q      <= '0;
      opb_q      <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      prod_q     <= prod_d;
      rem_q      <= rem_d;
      opb_q      <= opb_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_div_unit
//  Purpose  : Self-checking bench for mul_div_unit (WIDTH=32): vector table of
//             arithmetic cases plus hand sequences for handshake corners.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_div_unit;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   mdOp;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_cmp  = 0;
  int n_fail = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mdOp  (mdOp),
    .opA   (opA),
    .opB   (opB),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller is just past a negedge. Issues op (sampled at next posedge = E0),
  // then counts edges until done. With inj set, an MTHI is offered at E3 and
  // a MULT at E5 while the unit is busy.
  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit inj, output int lat);
    bit seen;
    seen  = 1'b0;
    lat   = 0;
    start = 1'b1; mdOp = op; opA = a; opB = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; opA = 32'hDEAD_BEEF; opB = 32'h0BAD_F00D;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) check({name, " busy@E1"}, {63'd0, busy}, 64'd1);
      if (done) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
      if (inj && k == 2) begin
        start = 1'b1; mdOp = 3'd5; opA = 32'h1234; opB = 32'h0;
      end else if (inj && k == 4) begin
        start = 1'b1; mdOp = 3'd1; opA = 32'h7; opB = 32'h9;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!seen) begin
      check({name, " done timeout"}, 64'd0, 64'd1);
    end else begin
      check({name, " latency"}, 64'(lat), 64'(LAT));
      check({name, " busy in done cycle"}, {63'd0, busy}, 64'd0);
    end
  endtask

  initial begin
    int  lat;
    bit  seen;

    vecs[0]  = '{"MULTU 7*6",        3'd2, 32'd7,        32'd6,        32'h0000_0000, 32'h0000_002A};
    vecs[1]  = '{"MULT -3*5",        3'd1, 32'hFFFF_FFFD, 32'd5,       32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2]  = '{"MULTU FFFFFFFD*5", 3'd2, 32'hFFFF_FFFD, 32'd5,       32'h0000_0004, 32'hFFFF_FFF1};
    vecs[3]  = '{"DIV -7/2",         3'd3, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{"DIVU 1/0",         3'd4, 32'd1,        32'd0,        32'h0000_0001, 32'hFFFF_FFFF};
    vecs[5]  = '{"DIV min/-1",       3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6]  = '{"MULT min*min",     3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[7]  = '{"DIV 7/-2",         3'd3, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8]  = '{"DIVU 100/7",       3'd4, 32'd100,      32'd7,        32'h0000_0002, 32'h0000_000E};
    vecs[9]  = '{"DIV -5/0",         3'd3, 32'hFFFF_FFFB, 32'd0,       32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[10] = '{"MULTU max*max",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[11] = '{"MULT -1*-1",       3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    reset = 1'b1; start = 1'b0; mdOp = 3'd0; opA = '0; opB = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    reset = 1'b0;

    // Arithmetic table
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat);
      check({vecs[i].name, " hi"}, {32'd0, hi}, {32'd0, vecs[i].exp_hi});
      check({vecs[i].name, " lo"}, {32'd0, lo}, {32'd0, vecs[i].exp_lo});
    end

    // Start while busy is ignored: DIV result and timing undisturbed
    run_op("DIV with interference", 3'd3, 32'd100, 32'd7, 1'b1, lat);
    check("interference hi", {32'd0, hi}, 64'd2);
    check("interference lo", {32'd0, lo}, 64'd14);
    @(negedge clk);
    check("interference no extra op busy", {63'd0, busy}, 64'd0);
    check("done is one cycle", {63'd0, done}, 64'd0);

    // Back-to-back: second op issued in the first op's done cycle
    run_op("b2b first", 3'd2, 32'd3, 32'd4, 1'b0, lat);
    check("b2b first lo", {32'd0, lo}, 64'd12);
    run_op("b2b second", 3'd2, 32'd5, 32'd6, 1'b0, lat);
    check("b2b second lo", {32'd0, lo}, 64'd30);
    check("b2b second hi", {32'd0, hi}, 64'd0);

    // Reset at E10 of a MULT aborts it
    @(negedge clk);
    start = 1'b1; mdOp = 3'd1; opA = 32'd9; opB = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort busy before reset", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort done", {63'd0, done}, 64'd0);
    check("abort hi", {32'd0, hi}, 64'd0);
    check("abort lo", {32'd0, lo}, 64'd0);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort no done pulse", {63'd0, seen}, 64'd0);

    // MTLO writes lo one edge later, no busy/done
    start = 1'b1; mdOp = 3'd6; opA = 32'hAB; opB = 32'h5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("MTLO lo", {32'd0, lo}, 64'hAB);
    check("MTLO hi", {32'd0, hi}, 64'd0);
    check("MTLO busy", {63'd0, busy}, 64'd0);
    check("MTLO done", {63'd0, done}, 64'd0);

    // NOP and reserved op with start change nothing
    start = 1'b1; mdOp = 3'd0; opA = 32'h1111; opB = 32'h2222;
    @(posedge clk);
    @(negedge clk);
    mdOp = 3'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("NOP busy", {63'd0, busy}, 64'd0);
    check("NOP hi", {32'd0, hi}, 64'd0);
    check("NOP lo", {32'd0, lo}, 64'hAB);

    // MTHI from idle
    start = 1'b1; mdOp = 3'd5; opA = 32'h55AA_0F0F; opB = 32'h0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("MTHI hi", {32'd0, hi}, 64'h55AA_0F0F);
    check("MTHI lo", {32'd0, lo}, 64'hAB);
    check("MTHI busy", {63'd0, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
